alu_operand_loader: RTL and testbench

ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

---
 rtl/alu_operand_loader_if.sv | 20 ++
 rtl/alu_operand_loader.sv | 61 ++++++
 tb/tb_alu_operand_loader.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_loader_if.sv
// alu_operand_loader_if: nibble stream in, ALU operand bundle out
interface alu_operand_loader_if;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic [2:0] out_ctrl;
    logic [3:0] out_samt;
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_ctrl, out_samt
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_a, out_b, out_ctrl, out_samt
    );
endinterface

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: assembles six nibbles into an ALU operand bundle
module alu_operand_loader (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       abort,
    alu_operand_loader_if.slave        bus,
    output logic                       err,
    output logic [7:0]                 frame_cnt
);
    typedef enum logic [2:0] {S_A0, S_A1, S_B0, S_B1, S_OP, S_SH, S_ISSUE} state_t;
    state_t state, state_nx;
    logic       accept, bad_op, xfer;
    logic [7:0] a_q, b_q;
    logic [2:0] op_q;
    assign accept = bus.in_valid && bus.in_ready && !abort;
    assign bad_op = accept && state == S_OP && bus.in_data[3];
    assign xfer   = bus.out_valid && bus.out_ready;
    always_ff @(posedge clk)
        state <= rst ? S_A0 : state_nx;
    always_comb begin
        state_nx = (abort || bad_op || xfer) ? S_A0 :
                   accept ? state_t'(state + 3'd1) : state;
    end
    always_comb begin
        bus.in_ready  = state != S_ISSUE;
        bus.out_valid = state == S_ISSUE;
    end
    // Fields assemble in shadow registers so out_* keep the last bundle until the next SH
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q           <= 8'h00;
            b_q           <= 8'h00;
            op_q          <= 3'd0;
            bus.out_a     <= 8'h00;
            bus.out_b     <= 8'h00;
            bus.out_ctrl  <= 3'd0;
            bus.out_samt  <= 4'd0;
            err           <= 1'b0;
            frame_cnt     <= 8'h00;
        end else begin
            err <= bad_op;
            if (xfer)
                frame_cnt <= frame_cnt + 8'd1;
            if (accept)
                case (state)
                    S_A0: a_q[3:0] <= bus.in_data;
                    S_A1: a_q[7:4] <= bus.in_data;
                    S_B0: b_q[3:0] <= bus.in_data;
                    S_B1: b_q[7:4] <= bus.in_data;
                    S_OP: op_q     <= bus.in_data[2:0];
                    S_SH: begin
                        bus.out_a    <= a_q;
                        bus.out_b    <= b_q;
                        bus.out_ctrl <= op_q;
                        bus.out_samt <= bus.in_data > 4'd8 ? 4'd8 : bus.in_data;
                    end
                    default: ;
                endcase
        end
    end
endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: directed checks of the operand loader
module tb_alu_operand_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       abort = 1'b0;
    logic       err;
    logic [7:0] frame_cnt;
    int         tests = 0;
    int         fails = 0;
    int         cnt = 0;
    int         k, cyc;
    logic [3:0] nib[6];
    alu_operand_loader_if bus();
    alu_operand_loader dut (
        .clk(clk), .rst(rst), .abort(abort), .bus(bus),
        .err(err), .frame_cnt(frame_cnt)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // n holds nibbles with the first one sent in the low four bits
    task automatic feed(input logic [23:0] n, input int num);
        for (int i = 0; i < num; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = n[4*i +: 4];
            tick();
        end
        bus.in_valid = 1'b0;
    endtask
    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'h0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_a", bus.out_a, 8'h00);
        chk("rst_cnt", frame_cnt, 0);
        rst = 1'b0;
        tick();
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_err", err, 0);
        feed(24'h2003A5, 6);
        chk("b2b_valid", bus.out_valid, 1);
        chk("b2b_a", bus.out_a, 8'hA5);
        chk("b2b_b", bus.out_b, 8'h03);
        chk("b2b_ctrl", bus.out_ctrl, 0);
        chk("b2b_samt", bus.out_samt, 2);
        chk("b2b_ready", bus.in_ready, 0);
        tick();
        chk("b2b_done", bus.out_valid, 0);
        chk("b2b_cnt", frame_cnt, 1);
        chk("b2b_hold_a", bus.out_a, 8'hA5);
        feed(24'h094321, 5);
        chk("badop_err", err, 1);
        chk("badop_valid", bus.out_valid, 0);
        chk("badop_ready", bus.in_ready, 1);
        tick();
        chk("badop_err_end", err, 0);
        chk("badop_cnt", frame_cnt, 1);
        chk("badop_hold_a", bus.out_a, 8'hA5);
        feed(24'h030007, 6);
        chk("after_a", bus.out_a, 8'h07);
        chk("after_b", bus.out_b, 8'h00);
        chk("after_ctrl", bus.out_ctrl, 3);
        tick();
        chk("after_cnt", frame_cnt, 2);
        bus.out_ready = 1'b0;
        feed(24'hF51234, 6);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h6;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_ready", bus.in_ready, 0);
            chk("stall_a", bus.out_a, 8'h34);
            chk("stall_b", bus.out_b, 8'h12);
            chk("stall_ctrl", bus.out_ctrl, 5);
            chk("stall_samt", bus.out_samt, 8);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("stall_done", bus.out_valid, 0);
        chk("stall_cnt", frame_cnt, 3);
        feed(24'h000FFF, 3);
        abort        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'hE;
        tick();
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_err", err, 0);
        chk("abort_valid", bus.out_valid, 0);
        feed(24'h110201, 6);
        chk("abort_a", bus.out_a, 8'h01);
        chk("abort_b", bus.out_b, 8'h02);
        chk("abort_ctrl", bus.out_ctrl, 1);
        chk("abort_samt", bus.out_samt, 1);
        tick();
        chk("abort_cnt", frame_cnt, 4);
        feed(24'h800000, 6);
        chk("sh8_samt", bus.out_samt, 8);
        tick();
        feed(24'h97FFFF, 6);
        chk("sh9_samt", bus.out_samt, 8);
        chk("sh9_a", bus.out_a, 8'hFF);
        chk("sh9_ctrl", bus.out_ctrl, 7);
        tick();
        chk("sh9_cnt", frame_cnt, 6);
        feed(24'h011111, 6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abxfer_valid", bus.out_valid, 0);
        chk("abxfer_cnt", frame_cnt, 7);
        chk("abxfer_ready", bus.in_ready, 1);
        bus.out_ready = 1'b0;
        feed(24'h022222, 6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        bus.out_ready = 1'b1;
        chk("abissue_valid", bus.out_valid, 0);
        chk("abissue_cnt", frame_cnt, 7);
        cnt = 7;
        for (int f = 0; f < 3; f++) begin
            k   = 0;
            cyc = 0;
            while (k < 6 && cyc < 200) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_data  = 4'($urandom_range(0, 15));
                if (k == 4) bus.in_data[3] = 1'b0;
                if (bus.in_valid) begin
                    nib[k] = bus.in_data;
                    k++;
                end
                tick();
                cyc++;
            end
            bus.in_valid = 1'b0;
            chk("rnd_nibbles", 8'(k), 6);
            chk("rnd_valid", bus.out_valid, 1);
            chk("rnd_a", bus.out_a, {nib[1], nib[0]});
            chk("rnd_b", bus.out_b, {nib[3], nib[2]});
            chk("rnd_ctrl", bus.out_ctrl, 8'(nib[4][2:0]));
            chk("rnd_samt", bus.out_samt, (nib[5] > 4'd8) ? 8'd8 : 8'(nib[5]));
            tick();
            cnt++;
            chk("rnd_cnt", frame_cnt, 8'(cnt));
        end
        for (int i = cnt; i < 255; i++) begin
            feed(24'h35A5B6, 6);
            tick();
        end
        chk("wrap_ff", frame_cnt, 8'hFF);
        feed(24'h35A5B6, 6);
        tick();
        chk("wrap_00", frame_cnt, 8'h00);
        chk("wrap_a", bus.out_a, 8'hB6);
        feed(24'h000321, 3);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        chk("rstb1_valid", bus.out_valid, 0);
        chk("rstb1_a", bus.out_a, 8'h00);
        chk("rstb1_b", bus.out_b, 8'h00);
        chk("rstb1_ctrl", bus.out_ctrl, 0);
        chk("rstb1_samt", bus.out_samt, 0);
        chk("rstb1_err", err, 0);
        chk("rstb1_cnt", frame_cnt, 0);
        tick();
        chk("rstb1_ready", bus.in_ready, 1);
        feed(24'h2003A5, 6);
        chk("post_rst_a", bus.out_a, 8'hA5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
